// File: rtl/alu_muldiv_ctrl.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide over
// operand magnitudes, one bit per cycle, with single-cycle divide-by-zero/overflow results.
module alu_muldiv_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            in_ready,
    output logic            stall,
    output logic            out_valid,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state;
    logic [5:0]          cnt;
    logic [2:0]          op;
    logic                neg_q;
    logic                neg_r;
    logic [XLEN-1:0]     a_mag;
    logic [XLEN-1:0]     b_mag;
    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     rem;

    logic                a_signed, b_signed, a_neg, b_neg;
    logic                accept, div_zero, div_ovf;
    logic [XLEN-1:0]     a_mag_in, b_mag_in, special_res;
    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_next, prod_fin;
    logic [XLEN:0]       div_shift, div_diff;
    logic                div_take;
    logic [XLEN-1:0]     rem_next, quot_next, quot_fin, rem_fin, calc_res;

    function automatic logic [XLEN-1:0] magnitude(input logic signed [XLEN-1:0] v,
                                                  input logic is_signed);
        return (is_signed && v[XLEN-1]) ? $unsigned(-v) : $unsigned(v);
    endfunction

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*XLEN-1:0] cond_neg_w(input logic [2*XLEN-1:0] v,
                                                     input logic neg);
        return neg ? -v : v;
    endfunction

    always_comb begin
        a_signed    = funct3[2] ? !funct3[0] : (funct3[1:0] != 2'b11);
        b_signed    = funct3[2] ? !funct3[0] : !funct3[1];
        a_neg       = a_signed && rs1[XLEN-1];
        b_neg       = b_signed && rs2[XLEN-1];
        a_mag_in    = magnitude(rs1, a_signed);
        b_mag_in    = magnitude(rs2, b_signed);
        div_zero    = funct3[2] && (rs2 == '0);
        div_ovf     = funct3[2] && !funct3[0] && (rs1 == {1'b1, {(XLEN-1){1'b0}}})
                      && (rs2 == '1);
        // Overflow DIV returns the dividend itself (the most negative value).
        special_res = div_zero ? (funct3[1] ? rs1 : '1) : (funct3[1] ? '0 : rs1);
        in_ready    = (state != CALC) && !flush;
        accept      = in_valid && in_ready;
        stall       = (state == CALC) || accept;
    end

    always_comb begin
        mul_sum   = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, a_mag} : '0);
        mul_next  = {mul_sum, prod[XLEN-1:1]};
        // Borrow out of the 33-bit trial subtraction means the divisor does not fit.
        div_shift = {rem, prod[XLEN-1]};
        div_diff  = div_shift - {1'b0, b_mag};
        div_take  = !div_diff[XLEN];
        rem_next  = div_take ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
        quot_next = {prod[XLEN-2:0], div_take};
        prod_fin  = cond_neg_w(mul_next, neg_q);
        quot_fin  = cond_neg(quot_next, neg_q);
        rem_fin   = cond_neg(rem_next, neg_r);
        case (op)
            3'b000:                 calc_res = prod_fin[XLEN-1:0];
            3'b001, 3'b010, 3'b011: calc_res = prod_fin[2*XLEN-1:XLEN];
            3'b100, 3'b101:         calc_res = quot_fin;
            default:                calc_res = rem_fin;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            op        <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            a_mag     <= '0;
            b_mag     <= '0;
            prod      <= '0;
            rem       <= '0;
            result    <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                CALC: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 6'd1;
                        if (op[2]) begin
                            prod[XLEN-1:0] <= quot_next;
                            rem            <= rem_next;
                        end else begin
                            prod <= mul_next;
                        end
                        if (cnt == 6'(XLEN-1)) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            result    <= calc_res;
                        end
                    end
                end
                default: begin
                    if (accept) begin
                        op    <= funct3;
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                        a_mag <= a_mag_in;
                        b_mag <= b_mag_in;
                        cnt   <= '0;
                        rem   <= '0;
                        prod  <= {{XLEN{1'b0}}, (funct3[2] ? a_mag_in : b_mag_in)};
                        if (div_zero || div_ovf) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            result    <= special_res;
                        end else begin
                            state <= CALC;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv_ctrl.sv
// Bench for alu_muldiv_ctrl: directed vector table, hand-written flush/reset/back-to-back
// sequences, and random ops checked against an arithmetic reference model.
module tb_alu_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        in_ready, stall, out_valid;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    alu_muldiv_ctrl #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .funct3(funct3), .rs1(rs1), .rs2(rs2),
        .flush(flush), .in_ready(in_ready), .stall(stall), .out_valid(out_valid),
        .result(result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb, ub;
        int          sa32, sb32;
        logic [63:0] p;
        logic        ovf;
        sa   = $signed(a);
        sb   = $signed(b);
        ub   = {32'h0, b};
        sa32 = a;
        sb32 = b;
        ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa32 / sb32);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(sa32 % sb32);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b);
        if (f3[2] && ((b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 1;
        return 33;
    endfunction

    // Present one op, then count cycles after the accepting edge until out_valid.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input string nm);
        int k;
        bit seen;
        bit stall_ok;
        @(negedge clk);
        in_valid = 1'b1; funct3 = f3; rs1 = a; rs2 = b;
        #1;
        chk({nm, "_ready"}, in_ready, 1);
        chk({nm, "_stall_acc"}, stall, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; funct3 = 3'($urandom); rs1 = $urandom; rs2 = $urandom;
        k = 0; seen = 0; stall_ok = 1;
        while (!seen && k < 40) begin
            @(negedge clk);
            k++;
            if (out_valid) seen = 1;
            else if (!stall) stall_ok = 0;
        end
        chk({nm, "_lat"}, seen ? k : -1, lat);
        chk({nm, "_res"}, result, exp);
        chk({nm, "_stall_calc"}, stall_ok, 1);
        chk({nm, "_stall_done"}, stall, 0);
        @(negedge clk);
        chk({nm, "_pulse"}, out_valid, 0);
        chk({nm, "_hold"}, result, exp);
    endtask

    task automatic expect_no_valid(input string nm, input int n);
        bit seen = 0;
        repeat (n) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        chk(nm, seen, 0);
    endtask

    // Accept an op, then return at the negedge of cycle T+k.
    task automatic start_and_wait(input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] b, input int k);
        @(negedge clk);
        in_valid = 1'b1; funct3 = f3; rs1 = a; rs2 = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (k) @(negedge clk);
    endtask

    initial begin
        int k;
        bit seen;
        logic [2:0]  f3;
        logic [31:0] a, b;
        int sel;

        vecs[0]  = '{3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
        vecs[1]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        vecs[2]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33};
        vecs[6]  = '{3'd5, 32'd100,       32'd7,         32'd14,        33};
        vecs[7]  = '{3'd7, 32'd100,       32'd7,         32'd2,         33};
        vecs[8]  = '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
        vecs[9]  = '{3'd6, 32'd5,         32'd0,         32'd5,         1};
        vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
        vecs[12] = '{3'd3, 32'h8000_0000, 32'd4,         32'd2,         33};
        vecs[13] = '{3'd7, 32'd3,         32'd10,        32'd3,         33};
        vecs[14] = '{3'd4, 32'h8000_0000, 32'd1,         32'h8000_0000, 33};
        vecs[15] = '{3'd5, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 33};

        #2 rst = 1'b1;
        #1;
        chk("rst_result", result, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_stall", stall, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);

        for (int i = 0; i < 16; i++)
            run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat,
                   $sformatf("vec%0d", i));

        // Flush in CALC at T+10.
        start_and_wait(3'd0, 32'd9, 32'd9, 10);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flush10_in_ready", in_ready, 1);
        expect_no_valid("flush10_no_valid", 40);

        // Flush in the last CALC cycle suppresses the result.
        start_and_wait(3'd0, 32'd9, 32'd9, 32);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        expect_no_valid("flush32_no_valid", 10);

        // Flush together with in_valid in IDLE.
        @(negedge clk);
        in_valid = 1'b1; funct3 = 3'd0; rs1 = 32'd2; rs2 = 32'd2; flush = 1'b1;
        #1;
        chk("flush_idle_ready", in_ready, 0);
        chk("flush_idle_stall", stall, 0);
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        expect_no_valid("flush_idle_no_valid", 40);
        chk("flush_idle_ready_after", in_ready, 1);

        // Reset mid-CALC of a DIV, with a non-zero result already held.
        run_op(3'd5, 32'd100, 32'd7, 32'd14, 33, "pre_rst");
        start_and_wait(3'd4, 32'd1000, 32'd3, 20);
        rst = 1'b1;
        #1;
        chk("midrst_result", result, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_stall", stall, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_in_ready", in_ready, 1);
        expect_no_valid("midrst_no_valid", 40);

        // Back-to-back MUL accepted in the DONE cycle.
        start_and_wait(3'd0, 32'd3, 32'd5, 0);
        k = 0; seen = 0;
        while (!seen && k < 40) begin
            @(negedge clk);
            k++;
            if (out_valid) seen = 1;
        end
        chk("b2b_first_lat", seen ? k : -1, 33);
        chk("b2b_first_res", result, 15);
        in_valid = 1'b1; funct3 = 3'd0; rs1 = 32'd6; rs2 = 32'd7;
        #1;
        chk("b2b_ready_in_done", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        k = 0; seen = 0;
        while (!seen && k < 40) begin
            @(negedge clk);
            k++;
            if (out_valid) seen = 1;
        end
        chk("b2b_second_lat", seen ? k : -1, 33);
        chk("b2b_second_res", result, 42);

        for (int i = 0; i < 40; i++) begin
            f3  = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) b = 0;
            else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (sel == 2) b = $urandom_range(1, 15);
            else if (sel == 3) a = $urandom_range(0, 255);
            run_op(f3, a, b, ref_result(f3, a, b), ref_lat(f3, a, b),
                   $sformatf("rnd%0d_f%0d", i, f3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_muldiv_ctrl.md
ALU_MULDIV_CTRL -- requirements
Module: alu_muldiv_ctrl

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, operand and result width; only 32 is supported.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1, EX stage presents an M-extension op (opcode 0110011, funct7 0000001).
REQ-005 The block SHALL have port funct3, input, 3, op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 The block SHALL have ports rs1 and rs2, input, 32 each, operands.
REQ-007 The block SHALL have port flush, input, 1, pipeline kill of the in-flight op.
REQ-008 The block SHALL have port in_ready, output, 1, the block accepts an op this cycle.
REQ-009 The block SHALL have port stall, output, 1, hold IF/ID/EX; high when the block is in CALC or when (in_valid && in_ready && !flush).
REQ-010 The block SHALL have port out_valid, output, 1, result valid; a one-cycle pulse.
REQ-011 The block SHALL have port result, output, 32, the result, held stable until the next op is accepted.

Function
REQ-012 The block SHALL implement the FSM states IDLE, CALC and DONE; in_ready SHALL be 1 only in IDLE and DONE with flush=0.
REQ-013 Acceptance SHALL occur on in_valid && in_ready && !flush; funct3, rs1 and rs2 SHALL be registered at acceptance, and later input changes SHALL be ignored.
REQ-014 On acceptance of a normal op, the FSM SHALL go to CALC and run a 6-bit counter through exactly 32 iterations, then go to DONE.
REQ-015 out_valid SHALL be asserted for one cycle on entering DONE; for a normal op accepted at edge T, out_valid SHALL be high in cycle T+33.
REQ-016 Multiply SHALL use a shift-add over operand magnitudes into a 64-bit product, with signedness per funct3: MULH s×s, MULHSU s×u, MULHU u×u.
REQ-017 The sign of the product SHALL be applied by two's-complement negation of the 64-bit product; MUL SHALL return bits [31:0], and MULH, MULHSU and MULHU SHALL return bits [63:32].
REQ-018 Divide SHALL use a restoring algorithm over magnitudes with a 32-bit quotient and a 33-bit partial remainder.
REQ-019 For signed division, the quotient SHALL be negated when the operand signs differ, and the remainder SHALL take the sign of rs1.
REQ-020 For divide by zero (rs2==0), the block SHALL skip CALC and go directly to DONE, giving out_valid at T+1.
REQ-021 For a divide by zero, DIV and DIVU SHALL return 0xFFFFFFFF, and REM and REMU SHALL return rs1.
REQ-022 For signed overflow (DIV or REM with rs1=0x80000000 and rs2=0xFFFFFFFF), the block SHALL skip CALC and give out_valid at T+1.
REQ-023 For signed overflow, DIV SHALL return 0x80000000 and REM SHALL return 0.
REQ-024 From DONE, the FSM SHALL go to CALC on a new acceptance (back-to-back ops allowed) and to IDLE otherwise.
REQ-025 A flush in CALC or DONE SHALL return the FSM to IDLE at the next edge with no out_valid; flush SHALL override in_valid in the same cycle.
REQ-026 A flush in the cycle before DONE is entered SHALL suppress out_valid.
REQ-027 stall SHALL deassert in the cycle out_valid is high, so the consumer captures result exactly once.

Reset
REQ-028 On rst, asynchronously: state SHALL be IDLE, the counter SHALL be 0, and all operand, product and remainder registers SHALL be 0.
REQ-029 On rst, asynchronously: result SHALL be 0, out_valid 0 and stall 0, with in_ready 1 after reset release.
REQ-030 An rst asserted mid-CALC SHALL abort the op, with no out_valid after release.

Verification
REQ-031 The bench SHALL cover: MUL rs1=7, rs2=0xFFFFFFFD accepted at T -> out_valid only at T+33, result 0xFFFFFFEB; stall high T..T+32.
REQ-032 The bench SHALL cover: MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU 0xFFFFFFFF×2 -> 0xFFFFFFFF.
REQ-033 The bench SHALL cover: DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
REQ-034 The bench SHALL cover: DIVU 5/0 -> 0xFFFFFFFF at T+1; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at T+1; REM same -> 0.
REQ-035 The bench SHALL cover: flush at T+10 of a MUL -> no out_valid, in_ready 1 at T+11; flush together with in_valid in IDLE -> op not accepted.
REQ-036 The bench SHALL cover: rst at T+20 of a DIV -> outputs 0 immediately; back-to-back MUL accepted in the DONE cycle -> second out_valid 33 cycles after the first.
